// File: rtl/eth_pkg.sv
// Shared definitions for the Ethernet transmit path: frame-scheduler state
// encoding, grant codes and retry counter width.
package eth_pkg;

    localparam int RETRY_W = 4;

    typedef logic [1:0] grant_t;

    localparam grant_t GRANT_NONE = 2'b00;
    localparam grant_t GRANT_DATA = 2'b01;
    localparam grant_t GRANT_CTRL = 2'b10;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_ACTIVE = 3'd2;
    localparam logic [2:0] ST_RETRY  = 3'd3;
    localparam logic [2:0] ST_DONE   = 3'd4;

endpackage

// File: rtl/eth_tx_frame_sched_if.sv
// Request/ack and tx-state-machine signals around the transmit frame scheduler.
// master = frame sources + tx state machine, slave = scheduler.
interface eth_tx_frame_sched_if;
    import eth_pkg::*;

    logic               DataReq;
    logic               CtrlReq;
    logic               StateIdle;
    logic               StateJam;
    logic               TxDone;
    logic               TxErr;
    logic               TxStartFrm;
    grant_t             Grant;
    logic [RETRY_W-1:0] RetryCnt;
    logic               RetryMax;
    logic               DataAck;
    logic               CtrlAck;
    logic               TxOk;
    logic               Busy;

    modport slave (
        input  DataReq, CtrlReq, StateIdle, StateJam, TxDone, TxErr,
        output TxStartFrm, Grant, RetryCnt, RetryMax, DataAck, CtrlAck, TxOk, Busy
    );

    modport master (
        output DataReq, CtrlReq, StateIdle, StateJam, TxDone, TxErr,
        input  TxStartFrm, Grant, RetryCnt, RetryMax, DataAck, CtrlAck, TxOk, Busy
    );

endinterface

// File: rtl/eth_tx_frame_sched.sv
// Transmit frame scheduler: arbitrates data vs control frames, launches the
// granted frame, counts collision retries and acks the requester on completion.
module eth_tx_frame_sched
    import eth_pkg::*;
#(
    parameter int RETRY_LIMIT = 15,
    parameter int CTRL_BURST  = 2
) (
    input  logic                 MTxClk,
    input  logic                 Reset,
    eth_tx_frame_sched_if.slave  bus
);

    localparam logic [RETRY_W-1:0] RETRY_LIM = RETRY_W'(RETRY_LIMIT);
    // ctrlRun saturates at 3, so a larger burst setting behaves like 3
    // instead of starving the data path forever.
    localparam logic [1:0] BURST_SAT = (CTRL_BURST > 3) ? 2'd3 : 2'(CTRL_BURST);

    logic [2:0]         state;
    grant_t             grant;
    logic [RETRY_W-1:0] retryCnt;
    logic [1:0]         ctrlRun;
    logic               jamQ;
    logic               txOkQ;

    logic retryMax;
    logic jamRise;
    logic anyReq;
    logic pickCtrl;

    assign retryMax = (retryCnt == RETRY_LIM);
    assign jamRise  = bus.StateJam & ~jamQ;
    assign anyReq   = bus.DataReq | bus.CtrlReq;
    assign pickCtrl = bus.CtrlReq & (~bus.DataReq | (ctrlRun < BURST_SAT));

    always_ff @(posedge MTxClk) begin
        if (Reset) begin
            state    <= ST_IDLE;
            grant    <= GRANT_NONE;
            retryCnt <= '0;
            ctrlRun  <= '0;
            jamQ     <= 1'b0;
            txOkQ    <= 1'b0;
        end else begin
            jamQ <= bus.StateJam;
            case (state)
                ST_IDLE: begin
                    if (bus.StateIdle && anyReq) begin
                        retryCnt <= '0;
                        state    <= ST_START;
                        if (pickCtrl) begin
                            grant <= GRANT_CTRL;
                            if (!bus.DataReq)
                                ctrlRun <= '0;
                            else if (ctrlRun != 2'd3)
                                ctrlRun <= ctrlRun + 2'd1;
                        end else begin
                            grant   <= GRANT_DATA;
                            ctrlRun <= '0;
                        end
                    end
                end
                // The tx state machine may sit in idle for carrier sense;
                // keep requesting until it actually leaves.
                ST_START: begin
                    if (!bus.StateIdle)
                        state <= ST_ACTIVE;
                end
                ST_ACTIVE: begin
                    if (bus.TxErr) begin
                        state <= ST_DONE;
                        txOkQ <= 1'b0;
                    end else if (bus.TxDone) begin
                        state <= ST_DONE;
                        txOkQ <= 1'b1;
                    end else if (jamRise) begin
                        if (retryMax) begin
                            state <= ST_DONE;
                            txOkQ <= 1'b0;
                        end else begin
                            retryCnt <= retryCnt + 1'b1;
                            state    <= ST_RETRY;
                        end
                    end
                end
                ST_RETRY: begin
                    if (bus.TxErr) begin
                        state <= ST_DONE;
                        txOkQ <= 1'b0;
                    end else if (bus.StateIdle) begin
                        state <= ST_START;
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                    grant <= GRANT_NONE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

    assign bus.TxStartFrm = (state == ST_START);
    assign bus.Grant      = grant;
    assign bus.RetryCnt   = retryCnt;
    assign bus.RetryMax   = retryMax;
    assign bus.DataAck    = (state == ST_DONE) && (grant == GRANT_DATA);
    assign bus.CtrlAck    = (state == ST_DONE) && (grant == GRANT_CTRL);
    assign bus.TxOk       = (state == ST_DONE) && txOkQ;
    assign bus.Busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_eth_tx_frame_sched.sv
// Scoreboard bench for eth_tx_frame_sched: two instances (retry limit 15 and 2),
// muxed onto one set of stimulus/observation signals by sel.
module tb_eth_tx_frame_sched;
    import eth_pkg::*;

    logic MTxClk = 1'b0;
    logic Reset  = 1'b1;
    always #5 MTxClk = ~MTxClk;

    logic sel = 1'b0;
    logic dataReq = 1'b0, ctrlReq = 1'b0, stIdle = 1'b1, stJam = 1'b0, txDone = 1'b0, txErr = 1'b0;

    eth_tx_frame_sched_if busA();
    eth_tx_frame_sched_if busB();

    eth_tx_frame_sched #(.RETRY_LIMIT(15), .CTRL_BURST(2)) dutA (.MTxClk(MTxClk), .Reset(Reset), .bus(busA));
    eth_tx_frame_sched #(.RETRY_LIMIT(2),  .CTRL_BURST(2)) dutB (.MTxClk(MTxClk), .Reset(Reset), .bus(busB));

    assign busA.DataReq   = !sel & dataReq;
    assign busA.CtrlReq   = !sel & ctrlReq;
    assign busA.StateIdle = stIdle;
    assign busA.StateJam  = !sel & stJam;
    assign busA.TxDone    = !sel & txDone;
    assign busA.TxErr     = !sel & txErr;
    assign busB.DataReq   = sel & dataReq;
    assign busB.CtrlReq   = sel & ctrlReq;
    assign busB.StateIdle = stIdle;
    assign busB.StateJam  = sel & stJam;
    assign busB.TxDone    = sel & txDone;
    assign busB.TxErr     = sel & txErr;

    logic       txStart, retryMax, dataAck, ctrlAck, txOk, busy;
    logic [1:0] grant;
    logic [3:0] retryCnt;
    assign txStart  = sel ? busB.TxStartFrm : busA.TxStartFrm;
    assign grant    = sel ? busB.Grant      : busA.Grant;
    assign retryCnt = sel ? busB.RetryCnt   : busA.RetryCnt;
    assign retryMax = sel ? busB.RetryMax   : busA.RetryMax;
    assign dataAck  = sel ? busB.DataAck    : busA.DataAck;
    assign ctrlAck  = sel ? busB.CtrlAck    : busA.CtrlAck;
    assign txOk     = sel ? busB.TxOk       : busA.TxOk;
    assign busy     = sel ? busB.Busy       : busA.Busy;

    typedef struct {
        logic [1:0] grant;
        logic       ok;
        logic [3:0] retry;
    } exp_t;

    exp_t q[$];
    int checks = 0;
    int failures = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    task automatic fail(input string name);
        checks++;
        failures++;
        $display("FAIL %s actual=none required=event", name);
    endtask

    task automatic tick();
        @(posedge MTxClk);
        #1;
    endtask

    task automatic pushExp(input logic [1:0] g, input logic ok, input logic [3:0] r);
        exp_t e;
        e.grant = g; e.ok = ok; e.retry = r;
        q.push_back(e);
    endtask

    // Monitor: grant checked on every TxStartFrm rise, ack contents on every ack.
    initial begin
        logic prevStart;
        exp_t e;
        prevStart = 1'b0;
        forever begin
            @(negedge MTxClk);
            if (txStart && !prevStart) begin
                if (q.size() == 0) fail("unexpected_start");
                else chk("grant", grant, q[0].grant);
            end
            prevStart = txStart;
            if (dataAck || ctrlAck) begin
                if (q.size() == 0) fail("unexpected_ack");
                else begin
                    e = q.pop_front();
                    chk("ack_kind", {ctrlAck, dataAck}, e.grant);
                    chk("ack_txok", txOk, e.ok);
                    chk("ack_retry", retryCnt, e.retry);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic waitStart(output int lat);
        lat = 0;
        while (!txStart && lat < 20) begin
            tick();
            lat++;
        end
        if (!txStart) fail("start_timeout");
    endtask

    // endMode: 0 TxDone, 1 TxErr in last RETRY, 3 reset in ACTIVE, 4 TxDone with jam.
    // Returns just after the edge that makes the ack visible.
    task automatic runFrame(input int jams, input int lim, input int endMode,
                            input bit withdraw, input int doneDelay, output int lat);
        int n;
        exp_t d;
        waitStart(lat);
        n = 0;
        while (txStart && n < 50) begin
            n++;
            if (n == 3) stIdle = 1'b0;
            tick();
        end
        chk("start_cycles", n, 3);
        if (withdraw) begin dataReq = 1'b0; ctrlReq = 1'b0; end
        for (int j = 0; j < jams; j++) begin
            tick();
            stJam = 1'b1;
            tick();
            stJam = 1'b0;
            if (j == lim) begin stIdle = 1'b1; return; end
            chk("retry_cnt", retryCnt, j + 1);
            chk("retry_max", retryMax, (j + 1 == lim));
            tick();
            tick();
            if (endMode == 1 && j == jams - 1) begin
                txErr = 1'b1; tick(); txErr = 1'b0; stIdle = 1'b1;
                return;
            end
            stIdle = 1'b1;
            tick();
            chk("restart", txStart, 1);
            stIdle = 1'b0;
            tick();
        end
        if (endMode == 3) begin
            tick();
            dataReq = 1'b0; ctrlReq = 1'b0;
            Reset = 1'b1;
            tick();
            chk("rst_start", txStart, 0);
            chk("rst_grant", grant, 0);
            chk("rst_ack", {ctrlAck, dataAck, txOk}, 0);
            chk("rst_busy", busy, 0);
            Reset = 1'b0;
            stIdle = 1'b1;
            d = q.pop_front();
            tick();
            chk("post_rst_quiet", {dataAck, busy}, 0);
        end else if (endMode == 4) begin
            tick();
            txDone = 1'b1; stJam = 1'b1;
            tick();
            txDone = 1'b0; stJam = 1'b0; stIdle = 1'b1;
        end else begin
            repeat (doneDelay) tick();
            txDone = 1'b1;
            tick();
            txDone = 1'b0; stIdle = 1'b1;
        end
    endtask

    initial begin
        int lat, dataPend, ctrlPend;
        logic [1:0] order [6];
        order[0] = GRANT_CTRL; order[1] = GRANT_CTRL; order[2] = GRANT_DATA;
        order[3] = GRANT_CTRL; order[4] = GRANT_CTRL; order[5] = GRANT_DATA;

        tick(); tick();
        chk("rst_txstart", txStart, 0);
        chk("rst_grant0", grant, 0);
        chk("rst_retrycnt", retryCnt, 0);
        chk("rst_retrymax", retryMax, 0);
        chk("rst_dataack", dataAck, 0);
        chk("rst_ctrlack", ctrlAck, 0);
        chk("rst_txok", txOk, 0);
        chk("rst_busy0", busy, 0);
        Reset = 1'b0;
        tick();

        // single data frame
        dataReq = 1'b1;
        pushExp(GRANT_DATA, 1'b1, 4'd0);
        runFrame(0, 15, 0, 1'b0, 50, lat);
        chk("req_to_start", lat, 1);
        chk("busy_at_ack", busy, 1);
        dataReq = 1'b0;
        tick();
        chk("busy_after_ack", busy, 0);
        chk("grant_after_ack", grant, 0);
        tick();

        // both requests held: ctrl, ctrl, data, ctrl, ctrl, data
        ctrlPend = 4; dataPend = 2;
        dataReq = 1'b1; ctrlReq = 1'b1;
        for (int k = 0; k < 6; k++) pushExp(order[k], 1'b1, 4'd0);
        for (int k = 0; k < 6; k++) begin
            runFrame(0, 15, 0, 1'b0, 2, lat);
            if (order[k] == GRANT_DATA) dataPend--; else ctrlPend--;
            dataReq = (dataPend > 0);
            ctrlReq = (ctrlPend > 0);
        end
        tick(); tick();

        // three collisions then success
        dataReq = 1'b1;
        pushExp(GRANT_DATA, 1'b1, 4'd3);
        runFrame(3, 15, 0, 1'b0, 5, lat);
        dataReq = 1'b0;
        tick(); tick();

        // TxErr while in RETRY
        ctrlReq = 1'b1;
        pushExp(GRANT_CTRL, 1'b0, 4'd1);
        runFrame(1, 15, 1, 1'b0, 0, lat);
        ctrlReq = 1'b0;
        tick(); tick();

        // request withdrawn in ACTIVE
        dataReq = 1'b1;
        pushExp(GRANT_DATA, 1'b1, 4'd0);
        runFrame(0, 15, 0, 1'b1, 4, lat);
        tick(); tick();

        // TxDone together with a jam rise: done wins, jam not counted
        dataReq = 1'b1;
        pushExp(GRANT_DATA, 1'b1, 4'd0);
        runFrame(0, 15, 4, 1'b0, 0, lat);
        dataReq = 1'b0;
        chk("done_jam_retry", retryCnt, 0);
        tick(); tick();

        // reset in ACTIVE: no ack
        dataReq = 1'b1;
        pushExp(GRANT_DATA, 1'b1, 4'd0);
        runFrame(0, 15, 3, 1'b0, 0, lat);
        tick(); tick();

        // retry exhaustion on the RETRY_LIMIT=2 instance
        sel = 1'b1;
        tick();
        dataReq = 1'b1;
        pushExp(GRANT_DATA, 1'b0, 4'd2);
        runFrame(3, 2, 0, 1'b0, 0, lat);
        dataReq = 1'b0;
        tick(); tick(); tick();

        chk("queue_empty", q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/eth_tx_frame_sched.md
# eth_tx_frame_sched

Transmit frame scheduler between the MAC frame sources and the transmit state machine (`eth_txstatem`). Arbitrates between data frames (descriptor path) and control/pause frames, and drives `TxStartFrm` to launch the granted frame. Tracks collision retries, driving `RetryMax` back to the state machine, and returns a one-cycle completion/abort acknowledge with status to the granted requester.

## Interface
- `RETRY_LIMIT`, default 15: retries allowed per frame before abort; must be ≤ 15.
- `CTRL_BURST`, default 2: consecutive control frames allowed while `DataReq` is pending before data gets priority; must be ≥ 1.
- `MTxClk` in 1: transmit clock. One clock; reset is synchronous and active-high.
- `Reset` in 1: synchronous, active-high.
- `DataReq` in 1: data frame pending; held until `DataAck`.
- `CtrlReq` in 1: control frame pending; held until `CtrlAck`.
- `StateIdle` in 1: from tx state machine.
- `StateJam` in 1: from tx state machine.
- `TxDone` in 1: one-cycle pulse, frame sent successfully.
- `TxErr` in 1: one-cycle pulse, fatal error (underrun / too big).
- `TxStartFrm` out 1: frame start request to the tx state machine.
- `Grant` out 2: `01` = data, `10` = control, `00` = none.
- `RetryCnt` out 4: retries used by the current frame.
- `RetryMax` out 1: `RetryCnt == RETRY_LIMIT`; to the tx state machine.
- `DataAck` / `CtrlAck` out 1: one-cycle completion pulses.
- `TxOk` out 1: valid with an ack; 1 = sent, 0 = aborted.
- `Busy` out 1: FSM not in IDLE.

## Operation
- States: IDLE, START, ACTIVE, RETRY, DONE.
- **IDLE:**
  - Entered when `StateIdle=1` and any request is pending.
  - Grant control if `CtrlReq & (~DataReq | ctrl_run < CTRL_BURST)`; otherwise grant data.
  - Latch `Grant`, clear `RetryCnt`, go to START.
- **`ctrl_run` (2-bit saturating):**
  - Increments on each control grant while `DataReq=1`.
  - Clears on any data grant, or when `DataReq=0` at grant time.
- **START:**
  - `TxStartFrm=1`, held until `StateIdle` samples 0 (state machine left idle, possibly delayed by carrier sense).
  - Then go to ACTIVE, with `TxStartFrm=0` in the same cycle.
- **ACTIVE, priority `TxErr` > `TxDone` > jam-rise:**
  - `TxErr` → DONE, `TxOk=0`.
  - `TxDone` → DONE, `TxOk=1`.
  - Rising edge of `StateJam` (registered `jam_q`):
    - If `RetryMax=1` → DONE, `TxOk=0`.
    - Else increment `RetryCnt` → RETRY.
- **RETRY:**
  - Wait for `StateIdle=1`, then go to START.
  - `TxErr` here → DONE, `TxOk=0`.
- **DONE:**
  - One cycle: pulse the ack selected by `Grant`, drive `TxOk`.
  - Next cycle: `Grant=00`, go to IDLE.
- Request deassertion after grant is ignored; the frame completes and is still acked.
- `TxDone`, `TxErr` and jam edges outside ACTIVE/RETRY are ignored.

## Timing
- Reset values (for one `Reset` cycle):
  - Outputs: `TxStartFrm=0`, `Grant=00`, `RetryCnt=0`, `RetryMax` reflects `RetryCnt=0` (1 only if `RETRY_LIMIT=0`), `DataAck=CtrlAck=0`, `TxOk=0`, `Busy=0`.
  - Internal: FSM=IDLE, `ctrl_run=0`, `jam_q=0`.
- `Reset` mid-frame aborts without an ack.
- Request to `TxStartFrm`: 1 cycle (IDLE registers grant; START drives `TxStartFrm` from the next edge).
- `TxDone`/`TxErr` to ack: ack asserts the cycle after the pulse; Busy drops one cycle later.
- Back-to-back: next grant no earlier than 2 cycles after the ack, and only with `StateIdle=1`.
- `RetryCnt` updates the cycle after the jam rising edge; `RetryMax` is combinational from `RetryCnt`.
- Simultaneous `TxDone` and jam-rise: `TxDone` wins; a late jam is not counted.
- Simultaneous `CtrlReq` and `DataReq` in IDLE: control wins unless `ctrl_run == CTRL_BURST`.

## Structure
- Shared package `eth_pkg`:
  - FSM state encoding.
  - `GRANT_DATA`/`GRANT_CTRL` constants.
  - Retry counter width.
- No sub-module; arbitration, retry counter and FSM are one module of about 200 lines.

## Test plan
- **Single data frame:**
  - Stimulus: `DataReq=1`, `StateIdle` drops 3 cycles after `TxStartFrm`, `TxDone` 50 cycles later.
  - Expected: `Grant=01`, `TxStartFrm` high exactly 3 cycles, `DataAck=1` with `TxOk=1`, `RetryCnt=0`.
- **Simultaneous requests, `CTRL_BURST=2`, both held:**
  - Expected grant order: ctrl, ctrl, data, ctrl, ctrl, data.
- **Three collisions then success:**
  - Stimulus: 3 `StateJam` rising edges, then `TxDone`.
  - Expected: `RetryCnt` goes 1, 2, 3; `TxStartFrm` re-asserted after each return of `StateIdle`; ack with `TxOk=1`.
- **Retry exhaustion, `RETRY_LIMIT=2`:**
  - Stimulus: 3 jam edges.
  - Expected: `RetryMax=1` after the 2nd; the 3rd gives an ack with `TxOk=0`.
- **Error and reset:**
  - `TxErr` in RETRY: immediate DONE, ack with `TxOk=0`.
  - `Reset` asserted in ACTIVE: all outputs return to reset values next cycle, no ack.
- **Request withdrawn:**
  - Stimulus: `DataReq` dropped while in ACTIVE.
  - Expected: frame still completes and `DataAck` still pulses.
